// File: rtl/serial_match_pkg.sv
// Shared definitions for the serial pattern-match controller.
//   state_t     : controller FSM states (IDLE, SHIFT, REPORT)
//   DEF_PAT_LEN : default pattern length
//   DEF_PAT     : default target pattern, MSB is the first bit received
//   clog2       : constant-function ceil(log2) used for width checks/sizing
package serial_match_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam int DEF_PAT_LEN = 5;
    localparam logic [DEF_PAT_LEN-1:0] DEF_PAT = 5'b10111;

    // ceil(log2(value)); returns 0 for value <= 1
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/serial_match_ctrl_if.sv
// Handshake bundle between the word producer / result consumer and the
// serial match controller.
//   IN_VALID/IN_READY/IN_DATA    : parallel word input handshake
//   OUT_VALID/OUT_READY          : result output handshake
//   OUT_COUNT/OUT_FIRST          : per-word match count and first-match index
//   MATCH                        : per-bit match pulse
// master = producer/consumer side, slave = controller side.
interface serial_match_ctrl_if #(
    parameter int WORD_W = 16,
    parameter int CNT_W  = 5
);
    logic              IN_VALID;
    logic              IN_READY;
    logic [WORD_W-1:0] IN_DATA;
    logic              MATCH;
    logic              OUT_VALID;
    logic              OUT_READY;
    logic [CNT_W-1:0]  OUT_COUNT;
    logic [CNT_W-1:0]  OUT_FIRST;

    modport master (
        output IN_VALID, IN_DATA, OUT_READY,
        input  IN_READY, MATCH, OUT_VALID, OUT_COUNT, OUT_FIRST
    );

    modport slave (
        input  IN_VALID, IN_DATA, OUT_READY,
        output IN_READY, MATCH, OUT_VALID, OUT_COUNT, OUT_FIRST
    );
endinterface

// File: rtl/pattern_window_det.sv
// Windowed serial pattern detector.
// Keeps the last PAT_LEN-1 bits plus a saturating count of how many valid
// bits have been seen, so no match can fire before a full window exists.
//   CLK, RST : clock, asynchronous active-high reset
//   clr      : synchronous clear of history and valid-bit counter (wins over bit_en)
//   bit_en   : bit_in is a live bit this cycle
//   bit_in   : serial bit
//   match    : combinational; bit_in completes PAT this cycle
module pattern_window_det
    import serial_match_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PAT     = DEF_PAT
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic bit_en,
    input  logic bit_in,
    output logic match
);

    localparam int                  CNT_BITS = clog2(PAT_LEN);
    localparam logic [CNT_BITS-1:0] CNT_MAX  = CNT_BITS'(PAT_LEN - 1);

    logic [PAT_LEN-2:0]  hist_q, hist_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [PAT_LEN-1:0]  window;

    // Oldest history bit lines up with PAT's MSB.
    assign window = {hist_q, bit_in};
    assign match  = bit_en && (cnt_q >= CNT_MAX) && (window == PAT);

    // History shifts in each live bit; the counter stops at PAT_LEN-1 since
    // past that point every window is fully populated.
    always_comb begin
        hist_d = hist_q;
        cnt_d  = cnt_q;
        if (clr) begin
            hist_d = '0;
            cnt_d  = '0;
        end else if (bit_en) begin
            hist_d = window[PAT_LEN-2:0];
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // History and counter registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hist_q <= '0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_match_ctrl.sv
// Serial match controller: accepts a parallel word, feeds it MSB-first into
// a pattern window detector one bit per cycle, and reports the number of
// matches ending inside the word plus the index of the first one.
//   CLK, RST : clock, asynchronous active-high reset
//   FLUSH    : synchronous abort (drops word in flight, clears history)
//   bus      : serial_match_ctrl_if slave (input word / result handshakes, MATCH)
module serial_match_ctrl
    import serial_match_pkg::*;
#(
    parameter int                 WORD_W  = 16,
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PAT     = DEF_PAT,
    parameter bit                 CARRY   = 1'b1,
    parameter int                 CNT_W   = 5
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                FLUSH,
    serial_match_ctrl_if.slave  bus
);

    if (CNT_W < clog2(WORD_W + 1)) begin : g_cnt_w_check
        $error("serial_match_ctrl: CNT_W too narrow for WORD_W");
    end
    if (PAT_LEN < 2 || PAT_LEN > 8 || WORD_W < PAT_LEN) begin : g_pat_len_check
        $error("serial_match_ctrl: PAT_LEN out of range");
    end

    // OUT_FIRST value meaning "no match in this word".
    localparam logic [CNT_W-1:0] FIRST_NONE = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(WORD_W - 1);

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    first_q, first_d;

    logic in_ready;
    logic out_valid;
    logic det_clr;
    logic det_en;
    logic det_match;

    pattern_window_det #(
        .PAT_LEN (PAT_LEN),
        .PAT     (PAT)
    ) u_det (
        .CLK    (CLK),
        .RST    (RST),
        .clr    (det_clr),
        .bit_en (det_en),
        .bit_in (shreg_q[WORD_W-1]),
        .match  (det_match)
    );

    // Next-state and handshake decode. FLUSH is applied last so it overrides
    // whatever the current state decided, including a pending accept.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        idx_d     = idx_q;
        count_d   = count_q;
        first_d   = first_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        det_clr   = 1'b0;
        det_en    = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.IN_VALID && !FLUSH) begin
                    shreg_d = bus.IN_DATA;
                    idx_d   = '0;
                    count_d = '0;
                    first_d = FIRST_NONE;
                    det_clr = !CARRY;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                det_en  = 1'b1;
                shreg_d = shreg_q << 1;
                if (det_match) begin
                    count_d = count_q + 1'b1;
                    if (first_q == FIRST_NONE) begin
                        first_d = idx_q;
                    end
                end
                // Index parks on the last bit rather than running to WORD_W.
                if (idx_q == LAST_IDX) begin
                    state_d = REPORT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            REPORT: begin
                out_valid = 1'b1;
                if (bus.OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (FLUSH) begin
            state_d   = IDLE;
            idx_d     = '0;
            count_d   = '0;
            first_d   = FIRST_NONE;
            det_clr   = 1'b1;
            out_valid = 1'b0;
        end
    end

    // Controller registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            count_q <= '0;
            first_q <= FIRST_NONE;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            first_q <= first_d;
        end
    end

    assign bus.IN_READY  = in_ready;
    assign bus.OUT_VALID = out_valid;
    assign bus.MATCH     = det_match;
    assign bus.OUT_COUNT = count_q;
    assign bus.OUT_FIRST = first_q;

endmodule

// File: tb/tb_serial_match_ctrl.sv
// Self-checking bench for serial_match_ctrl. Two instances share every input:
// dut_a carries detector history across words, dut_b clears it per word.
module tb_serial_match_ctrl;

    localparam int WORD_W = 16;
    localparam int CNT_W  = 5;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              FLUSH = 1'b0;
    logic              in_valid = 1'b0;
    logic [WORD_W-1:0] in_data = '0;
    logic              out_ready = 1'b1;

    int compared   = 0;
    int mismatched = 0;

    serial_match_ctrl_if #(.WORD_W(WORD_W), .CNT_W(CNT_W)) bus_a ();
    serial_match_ctrl_if #(.WORD_W(WORD_W), .CNT_W(CNT_W)) bus_b ();

    assign bus_a.IN_VALID  = in_valid;
    assign bus_a.IN_DATA   = in_data;
    assign bus_a.OUT_READY = out_ready;
    assign bus_b.IN_VALID  = in_valid;
    assign bus_b.IN_DATA   = in_data;
    assign bus_b.OUT_READY = out_ready;

    serial_match_ctrl #(
        .WORD_W(WORD_W), .PAT_LEN(5), .PAT(5'b10111), .CARRY(1'b1), .CNT_W(CNT_W)
    ) dut_a (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .bus(bus_a)
    );

    serial_match_ctrl #(
        .WORD_W(WORD_W), .PAT_LEN(5), .PAT(5'b10111), .CARRY(1'b0), .CNT_W(CNT_W)
    ) dut_b (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .bus(bus_b)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [WORD_W-1:0] word;
        int                count_a;
        int                first_a;
        int                count_b;
        int                first_b;
    } vec_t;

    vec_t vecs [7];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared = compared + 1;
        if (actual != expected) begin
            mismatched = mismatched + 1;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Present a word and wait (bounded) until it is taken; returns just after
    // the accepting edge, i.e. while bit 0 is being processed.
    task automatic sendWord(input logic [WORD_W-1:0] word);
        in_data  = word;
        in_valid = 1'b1;
        for (int i = 0; i < 40 && !bus_a.IN_READY; i++) begin
            step();
        end
        checkOutput("accept_ready", int'(bus_a.IN_READY), 1);
        step();
        in_valid = 1'b0;
    endtask

    // Walk cycles after an accept until OUT_VALID; cycle 1 is bit 0.
    task automatic collect(output int valid_k, output int pulses, output int first_k,
                           output int cnt_a, output int fst_a,
                           output int cnt_b, output int fst_b, output int valid_b);
        int k;
        valid_k = -1;
        pulses  = 0;
        first_k = -1;
        cnt_a   = -1;
        fst_a   = -1;
        cnt_b   = -1;
        fst_b   = -1;
        valid_b = 0;
        k = 1;
        while (k <= 40) begin
            if (bus_a.MATCH) begin
                pulses = pulses + 1;
                if (first_k < 0) first_k = k;
            end
            if (bus_a.OUT_VALID) begin
                valid_k = k;
                cnt_a   = int'(bus_a.OUT_COUNT);
                fst_a   = int'(bus_a.OUT_FIRST);
                cnt_b   = int'(bus_b.OUT_COUNT);
                fst_b   = int'(bus_b.OUT_FIRST);
                valid_b = int'(bus_b.OUT_VALID);
                break;
            end
            step();
            k = k + 1;
        end
        if (valid_k < 0) begin
            checkOutput("result_timeout", 0, 1);
        end
    endtask

    // Full word transaction with OUT_READY held high.
    task automatic applyStimulus(input vec_t v);
        int valid_k, pulses, first_k, cnt_a, fst_a, cnt_b, fst_b, valid_b;
        sendWord(v.word);
        collect(valid_k, pulses, first_k, cnt_a, fst_a, cnt_b, fst_b, valid_b);
        checkOutput("out_valid_latency", valid_k, 17);
        checkOutput("match_pulses", pulses, v.count_a);
        if (v.count_a > 0) begin
            checkOutput("first_match_cycle", first_k, v.first_a + 1);
        end
        checkOutput("count_carry", cnt_a, v.count_a);
        checkOutput("first_carry", fst_a, v.first_a);
        checkOutput("valid_nocarry", valid_b, 1);
        checkOutput("count_nocarry", cnt_b, v.count_b);
        checkOutput("first_nocarry", fst_b, v.first_b);
        step();
        checkOutput("out_valid_one_cycle", int'(bus_a.OUT_VALID), 0);
        checkOutput("in_ready_after_report", int'(bus_a.IN_READY), 1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_in_ready"}, int'(bus_a.IN_READY), 1);
        checkOutput({tag, "_out_valid"}, int'(bus_a.OUT_VALID), 0);
        checkOutput({tag, "_match"}, int'(bus_a.MATCH), 0);
        checkOutput({tag, "_count"}, int'(bus_a.OUT_COUNT), 0);
        checkOutput({tag, "_first"}, int'(bus_a.OUT_FIRST), WORD_W);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int valid_k, pulses, first_k, cnt_a, fst_a, cnt_b, fst_b, valid_b;
        int ov_seen;

        vecs[0] = '{16'hB800, 1, 4,  1, 4};
        vecs[1] = '{16'hBB80, 2, 4,  2, 4};
        vecs[2] = '{16'h0000, 0, 16, 0, 16};
        vecs[3] = '{16'hFFFF, 0, 16, 0, 16};
        vecs[4] = '{16'h5DDD, 3, 5,  3, 5};
        vecs[5] = '{16'h000B, 0, 16, 0, 16};
        vecs[6] = '{16'h8000, 1, 0,  0, 16};

        // Reset values
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #3;
        checkResetValues("reset");
        RST = 1'b0;
        step();
        checkResetValues("post_reset");

        // Table-driven words, including the cross-word carry pair at the end
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
        end

        // Backpressure: result held while OUT_READY is low and IN_VALID is high
        out_ready = 1'b0;
        sendWord(16'hB800);
        collect(valid_k, pulses, first_k, cnt_a, fst_a, cnt_b, fst_b, valid_b);
        checkOutput("bp_latency", valid_k, 17);
        in_data  = 16'hBB80;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("bp_out_valid", int'(bus_a.OUT_VALID), 1);
            checkOutput("bp_count", int'(bus_a.OUT_COUNT), 1);
            checkOutput("bp_first", int'(bus_a.OUT_FIRST), 4);
            checkOutput("bp_in_ready", int'(bus_a.IN_READY), 0);
        end
        out_ready = 1'b1;
        step();
        checkOutput("bp_release_in_ready", int'(bus_a.IN_READY), 1);
        checkOutput("bp_release_out_valid", int'(bus_a.OUT_VALID), 0);
        step();
        checkOutput("bp_next_accepted", int'(bus_a.IN_READY), 0);
        in_valid = 1'b0;
        collect(valid_k, pulses, first_k, cnt_a, fst_a, cnt_b, fst_b, valid_b);
        checkOutput("bp_next_latency", valid_k, 17);
        checkOutput("bp_next_count", cnt_a, 2);
        checkOutput("bp_next_first", fst_a, 4);
        step();

        // FLUSH together with IN_VALID in IDLE: word must not be taken
        in_data  = 16'hB800;
        in_valid = 1'b1;
        FLUSH    = 1'b1;
        step();
        FLUSH    = 1'b0;
        in_valid = 1'b0;
        checkOutput("flush_idle_not_accepted", int'(bus_a.IN_READY), 1);
        step();
        checkOutput("flush_idle_still_idle", int'(bus_a.IN_READY), 1);

        // FLUSH while bit 7 of 0xBB80 is in flight
        sendWord(16'hBB80);
        repeat (7) step();
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
        checkOutput("flush_in_ready", int'(bus_a.IN_READY), 1);
        checkOutput("flush_out_valid", int'(bus_a.OUT_VALID), 0);
        checkOutput("flush_count", int'(bus_a.OUT_COUNT), 0);
        checkOutput("flush_first", int'(bus_a.OUT_FIRST), WORD_W);
        ov_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus_a.OUT_VALID) ov_seen = ov_seen + 1;
        end
        checkOutput("flush_no_result", ov_seen, 0);
        applyStimulus('{16'h8000, 0, 16, 0, 16});

        // Asynchronous reset while bit 8 of 0xBB80 is matching
        sendWord(16'hBB80);
        repeat (8) step();
        #2;
        RST = 1'b1;
        #1;
        checkResetValues("async_reset");
        #3;
        RST = 1'b0;
        step();
        checkOutput("after_reset_in_ready", int'(bus_a.IN_READY), 1);
        applyStimulus('{16'hB800, 1, 4, 1, 4});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
